// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels between a producer and alu_cmd_sequencer.
// The master side issues commands and consumes responses; the sequencer is the slave.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_eq;
    logic       rsp_a_gt_b;
    logic       rsp_b_gt_a;
    logic [1:0] rsp_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_eq, rsp_a_gt_b, rsp_b_gt_a, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_eq, rsp_a_gt_b, rsp_b_gt_a, rsp_op
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives registered operands/select onto a 4-bit combinational ALU, waits SETTLE_CYCLES,
// then captures the op-relevant outputs and returns them on a valid/ready response channel.
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [1:0]           alu_s,
    input  logic [3:0]           alu_final,
    input  logic                 alu_carry,
    input  logic                 alu_eq,
    input  logic                 alu_a_gt_b,
    input  logic                 alu_b_gt_a,
    output logic [CNT_W-1:0]     done_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_settle_cnt;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [1:0]       r_alu_s;
    logic [3:0]       r_rsp_data;
    logic             r_rsp_carry;
    logic             r_rsp_eq;
    logic             r_rsp_a_gt_b;
    logic             r_rsp_b_gt_a;
    logic [1:0]       r_rsp_op;
    logic [CNT_W-1:0] r_done_count;
    logic             w_accept;
    logic             w_settled;
    logic             w_rsp_fire;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Handshake outputs are decoded from state only, so neither ready nor valid sees an input combinationally.
    always_comb begin
        w_next_state  = r_state;
        bus.cmd_ready = (r_state == IDLE);
        bus.rsp_valid = (r_state == RESP);
        w_accept      = bus.cmd_ready && bus.cmd_valid;
        w_settled     = (r_state == SETTLE) && (r_settle_cnt == 4'd0);
        w_rsp_fire    = bus.rsp_valid && bus.rsp_ready;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = SETTLE;
            SETTLE:  if (w_settled)  w_next_state = RESP;
            RESP:    if (w_rsp_fire) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_s      <= '0;
            r_rsp_data   <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_eq     <= 1'b0;
            r_rsp_a_gt_b <= 1'b0;
            r_rsp_b_gt_a <= 1'b0;
            r_rsp_op     <= '0;
            r_done_count <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= bus.cmd_a;
                r_alu_b      <= bus.cmd_b;
                r_alu_s      <= bus.cmd_op;
                r_settle_cnt <= LP_SETTLE_LOAD;
            end else if ((r_state == SETTLE) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end

            // The ALU leaves stale values on unselected outputs; keep only what the op defines.
            if (w_settled) begin
                r_rsp_op <= r_alu_s;
                case (r_alu_s)
                    2'b00, 2'b01: begin
                        r_rsp_data   <= alu_final;
                        r_rsp_carry  <= alu_carry;
                        r_rsp_eq     <= 1'b0;
                        r_rsp_a_gt_b <= 1'b0;
                        r_rsp_b_gt_a <= 1'b0;
                    end
                    2'b10: begin
                        r_rsp_data   <= '0;
                        r_rsp_carry  <= 1'b0;
                        r_rsp_eq     <= alu_eq;
                        r_rsp_a_gt_b <= alu_a_gt_b;
                        r_rsp_b_gt_a <= alu_b_gt_a;
                    end
                    default: begin
                        r_rsp_data   <= alu_final;
                        r_rsp_carry  <= 1'b0;
                        r_rsp_eq     <= 1'b0;
                        r_rsp_a_gt_b <= 1'b0;
                        r_rsp_b_gt_a <= 1'b0;
                    end
                endcase
            end

            if (w_rsp_fire) r_done_count <= r_done_count + CNT_W'(1);
        end
    end

    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_s          = r_alu_s;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_eq     = r_rsp_eq;
    assign bus.rsp_a_gt_b = r_rsp_a_gt_b;
    assign bus.rsp_b_gt_a = r_rsp_b_gt_a;
    assign bus.rsp_op     = r_rsp_op;
    assign done_count     = r_done_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE_CYCLES 1 and 4) each driving a behavioural ALU
// that leaves stale values on unselected outputs; responses are checked against a reference model.
module tb_alu_cmd_sequencer;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       cmd_valid [ND];
    logic [3:0] cmd_a     [ND];
    logic [3:0] cmd_b     [ND];
    logic [1:0] cmd_op    [ND];
    logic       cmd_ready [ND];
    logic       rsp_valid [ND];
    logic       rsp_ready [ND];
    logic [3:0] rsp_data  [ND];
    logic       rsp_carry [ND];
    logic       rsp_eq    [ND];
    logic       rsp_agb   [ND];
    logic       rsp_bga   [ND];
    logic [1:0] rsp_op    [ND];
    logic [3:0] alu_a     [ND];
    logic [3:0] alu_b     [ND];
    logic [1:0] alu_s     [ND];
    logic [7:0] done_count[ND];

    typedef struct packed {
        logic [3:0] data;
        logic       carry;
        logic       eq;
        logic       agb;
        logic       bga;
        logic [1:0] op;
        logic [7:0] cnt;
    } rsp_t;

    rsp_t       q0[$];
    rsp_t       q1[$];
    logic [7:0] issued  [ND];
    bit         rdy_rand[ND];
    bit         rdy_val [ND];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: the response as the operation's definition says it should look.
    function automatic rsp_t ref_rsp(int a, int b, int op, logic [7:0] cnt);
        rsp_t r;
        r     = '0;
        r.op  = 2'(op);
        r.cnt = cnt;
        case (op)
            0: begin r.data = 4'((a + b) % 16);      r.carry = (a + b) > 15; end
            1: begin r.data = 4'((a - b + 16) % 16); r.carry = (a >= b);     end
            2: begin r.eq = (a == b); r.agb = (a > b); r.bga = (a < b);      end
            default: r.data = 4'(a & b);
        endcase
        return r;
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic rsp_t qpop(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(int d, int a, int b, int op);
        rsp_t e;
        e = ref_rsp(a, b, op, issued[d]);
        issued[d] = issued[d] + 8'd1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            alu_cmd_sequencer_if bus ();
            logic [3:0] af;
            logic       ac, ae, ag, al;
            rsp_t       act;
            rsp_t       snap;
            bit         stalled = 1'b0;

            assign bus.cmd_valid = cmd_valid[g];
            assign bus.cmd_a     = cmd_a[g];
            assign bus.cmd_b     = cmd_b[g];
            assign bus.cmd_op    = cmd_op[g];
            assign bus.rsp_ready = rsp_ready[g];
            assign cmd_ready[g]  = bus.cmd_ready;
            assign rsp_valid[g]  = bus.rsp_valid;
            assign rsp_data[g]   = bus.rsp_data;
            assign rsp_carry[g]  = bus.rsp_carry;
            assign rsp_eq[g]     = bus.rsp_eq;
            assign rsp_agb[g]    = bus.rsp_a_gt_b;
            assign rsp_bga[g]    = bus.rsp_b_gt_a;
            assign rsp_op[g]     = bus.rsp_op;

            alu_cmd_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 4), .CNT_W(8)) dut (
                .clk        (clk),
                .rst        (rst),
                .bus        (bus),
                .alu_a      (alu_a[g]),
                .alu_b      (alu_b[g]),
                .alu_s      (alu_s[g]),
                .alu_final  (af),
                .alu_carry  (ac),
                .alu_eq     (ae),
                .alu_a_gt_b (ag),
                .alu_b_gt_a (al),
                .done_count (done_count[g])
            );

            // ALU model: every output is always driven, so unselected ones carry junk.
            always_comb begin
                logic [4:0] t_add;
                logic [4:0] t_sub;
                t_add = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
                t_sub = {1'b0, alu_a[g]} + {1'b0, ~alu_b[g]} + 5'd1;
                case (alu_s[g])
                    2'b00:   af = t_add[3:0];
                    2'b01:   af = t_sub[3:0];
                    2'b10:   af = alu_a[g] ^ alu_b[g];
                    default: af = alu_a[g] & alu_b[g];
                endcase
                ac = (alu_s[g] == 2'b01) ? t_sub[4] : t_add[4];
                ae = (alu_a[g] == alu_b[g]);
                ag = (alu_a[g] >  alu_b[g]);
                al = (alu_a[g] <  alu_b[g]);
            end

            always @(negedge clk) begin
                act = {rsp_data[g], rsp_carry[g], rsp_eq[g], rsp_agb[g], rsp_bga[g], rsp_op[g], done_count[g]};
                if (rst || !rsp_valid[g]) begin
                    stalled = 1'b0;
                end else begin
                    chk($sformatf("cmd_ready_busy%0d", g), 32'(cmd_ready[g]), 32'd0);
                    if (stalled) chk($sformatf("rsp_hold%0d", g), 32'(act), 32'(snap));
                    if (rsp_ready[g]) begin
                        if (qsize(g) == 0) chk($sformatf("unexpected_rsp%0d", g), 32'd1, 32'd0);
                        else               chk($sformatf("rsp%0d", g), 32'(act), 32'(qpop(g)));
                        stalled = 1'b0;
                    end else begin
                        snap    = act;
                        stalled = 1'b1;
                    end
                end
            end
        end
    endgenerate

    initial begin
        for (int d = 0; d < ND; d++) rsp_ready[d] = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < ND; d++)
                rsp_ready[d] = rdy_rand[d] ? ($urandom_range(0, 3) != 0) : rdy_val[d];
        end
    end

    task automatic issue(int d, int a, int b, int op);
        int n;
        cmd_a[d]     = 4'(a);
        cmd_b[d]     = 4'(b);
        cmd_op[d]    = 2'(op);
        cmd_valid[d] = 1'b1;
        n = 0;
        while (!cmd_ready[d] && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready[d]) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        qpush(d, a, b, op);
        #1;
        cmd_valid[d] = 1'b0;
    endtask

    task automatic drain(int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || rsp_valid[d]) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (qsize(d) != 0 || rsp_valid[d]) chk("drain_timeout", 32'(qsize(d)), 32'd0);
    endtask

    task automatic check_reset(int d);
        chk($sformatf("reset_vals%0d", d),
            32'({cmd_ready[d], rsp_valid[d], alu_a[d], alu_b[d], alu_s[d], rsp_data[d], rsp_carry[d],
                 rsp_eq[d], rsp_agb[d], rsp_bga[d], rsp_op[d], done_count[d]}),
            32'h2000_0000);
    endtask

    task automatic rand_cmd(int d);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        issue(d, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_a[d]     = '0;
            cmd_b[d]     = '0;
            cmd_op[d]    = '0;
            issued[d]    = '0;
            rdy_rand[d]  = 1'b0;
            rdy_val[d]   = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < ND; d++) check_reset(d);

        // Add 9+8 with SETTLE_CYCLES=1: response one edge after accept.
        issue(0, 9, 8, 0);
        chk("add_not_yet_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("add_valid_k1", 32'(rsp_valid[0]), 32'd1);
        chk("add_data", 32'({rsp_data[0], rsp_carry[0]}), 32'h03);
        drain(0);
        chk("add_done_count", 32'(done_count[0]), 32'd1);

        // Compare then AND, back to back.
        issue(0, 7, 7, 2);
        issue(0, 4'b1100, 4'b1010, 3);
        drain(0);

        // Sub under backpressure.
        rdy_val[0] = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 5, 3, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 32'({cmd_ready[0], rsp_valid[0], rsp_data[0]}), 32'h12);
            @(posedge clk);
            #1;
        end
        rdy_val[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'({cmd_ready[0], rsp_valid[0]}), 32'h2);
        chk("bp_done_count", 32'(done_count[0]), 32'd4);

        // SETTLE_CYCLES=4: operands frozen, ignored input changes, valid exactly after edge k+4.
        rdy_val[1] = 1'b0;
        @(posedge clk);
        #1;
        issue(1, 10, 6, 1);
        cmd_a[1]     = 4'hF;
        cmd_b[1]     = 4'h0;
        cmd_op[1]    = 2'b11;
        cmd_valid[1] = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("settle4_alu_c%0d", i), 32'({alu_a[1], alu_b[1], alu_s[1]}), 32'({4'hA, 4'h6, 2'b01}));
            chk($sformatf("settle4_valid_c%0d", i), 32'(rsp_valid[1]), 32'(i == 4));
        end
        cmd_valid[1] = 1'b0;
        rdy_val[1]   = 1'b1;
        drain(1);
        chk("alu_held_after_resp", 32'({alu_a[1], alu_b[1], alu_s[1]}), 32'({4'hA, 4'h6, 2'b01}));

        // Reset while DUT1 is settling: no response, all back to reset values.
        issue(1, 3, 4, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        for (int d = 0; d < ND; d++) begin
            issued[d] = '0;
            check_reset(d);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("no_rsp_after_reset", 32'({rsp_valid[1], cmd_ready[1]}), 32'h1);
        end

        // Counter wrap with random traffic and random backpressure.
        rdy_rand[0] = 1'b1;
        for (int i = 0; i < 256; i++) rand_cmd(0);
        drain(0);
        chk("wrap_256", 32'(done_count[0]), 32'd0);
        rand_cmd(0);
        drain(0);
        chk("wrap_257", 32'(done_count[0]), 32'd1);

        rdy_rand[1] = 1'b1;
        for (int i = 0; i < 40; i++) rand_cmd(1);
        drain(1);
        chk("dut1_done_count", 32'(done_count[1]), 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 4-bit combinational ALU. It accepts one operation at a time over a valid/ready command channel and drives registered operands and select onto the ALU. It waits a programmable number of settle cycles, then samples the ALU outputs. It returns them on a valid/ready response channel with a running completion count.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: number of clock cycles the ALU inputs are held before its outputs are sampled; legal range 1–15.
- CNT_W, default 8: width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_op  in  2  00 add, 01 sub, 10 compare, 11 AND (ALU S encoding).
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_s  out  2  registered select to ALU.
- alu_final  in  4  ALU result.
- alu_carry  in  1  ALU carry out.
- alu_eq, alu_a_gt_b, alu_b_gt_a  in  1 each  ALU compare flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  4  captured result.
- rsp_carry  out  1  captured carry.
- rsp_eq, rsp_a_gt_b, rsp_b_gt_a  out  1 each  captured compare flags.
- rsp_op  out  2  op of the captured response.
- done_count  out  CNT_W  responses completed since reset.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_s.
  - Load settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, sample the ALU outputs into the rsp_* registers, set rsp_valid=1 and go to RESP.
- Capture rules by op:
  - add/sub: rsp_data=alu_final, rsp_carry=alu_carry, all rsp compare flags 0.
  - compare: rsp_data=0, rsp_carry=0, rsp_eq/rsp_a_gt_b/rsp_b_gt_a = ALU flags.
  - AND: rsp_data=alu_final, rsp_carry=0, flags 0.
  - Reason: the ALU holds stale values on unselected outputs, so the sequencer masks them.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid←0, done_count←done_count+1 (modulo 2^CNT_W, wraps to 0), go to IDLE.
- alu_a/alu_b/alu_s hold their last values until the next accepted command; they are never changed outside IDLE.
- cmd_op values are all legal; there is no error path.
- A command presented outside IDLE is not accepted and must be held by the producer.

## Timing
- Reset values (rst sampled high at an edge):
  - state=IDLE, cmd_ready=1.
  - alu_a=alu_b=0, alu_s=00.
  - rsp_valid=0, rsp_data=0, rsp_carry=0, all rsp flags 0, rsp_op=00.
  - done_count=0.
- Reset mid-operation (SETTLE or RESP) discards the in-flight command and returns to the reset values; no response is produced.
- Accept at edge k:
  - alu_* valid after edge k.
  - rsp_valid rises after edge k+SETTLE_CYCLES.
- Minimum command-to-command spacing: SETTLE_CYCLES+2 cycles, with rsp_ready tied high.
  - cmd_ready returns high the cycle after the response handshake edge.
- No combinational path from cmd_valid to cmd_ready, or from rsp_ready to rsp_valid.
- cmd_ready depends only on state.
- Response handshake and counter increment occur on the same edge.

## Test plan
- Add, SETTLE_CYCLES=1, rsp_ready=1: A=9, B=8, op=00 accepted at edge k → rsp_valid after edge k+1 with rsp_data=0001, rsp_carry=1, rsp_op=00, flags 0; done_count=1.
- Compare then AND back-to-back:
  - A=7, B=7, op=10 → rsp_eq=1, rsp_a_gt_b=0, rsp_b_gt_a=0, rsp_data=0, rsp_carry=0.
  - Then A=1100, B=1010, op=11 → rsp_data=1000, rsp_carry=0, flags 0.
- Backpressure, sub A=5, B=3, op=01, rsp_ready low 5 cycles:
  - rsp_valid and rsp_data=0010 stable all 5 cycles.
  - cmd_ready=0 throughout.
  - Raising rsp_ready completes the handshake at one edge; cmd_ready=1 on the next cycle.
- SETTLE_CYCLES=4: alu_a/alu_b/alu_s stable for 4 cycles after accept; rsp_valid rises exactly after edge k+4. Changing cmd_a while not ready has no effect on alu_a.
- Reset in SETTLE: assert rst one cycle after accept → rsp_valid never rises, all outputs at reset values, cmd_ready=1, done_count=0.
- Counter wrap, CNT_W=8: 256 completed commands → done_count returns to 0; 257th completion → 1.
